// File: rtl/wb_pkg.sv
// Shared widths and lane-field offsets for the multi-lane writeback stage.
// A lane is packed {valid, rf_we, rf_waddr, rf_wdata, pc, inst}, with inst in the LSBs.
package wb_pkg;

    localparam int RF_ADDR_W = 5;

    function automatic int lane_bits(input int xlen, input int pc_w, input int inst_w);
        return 2 + RF_ADDR_W + xlen + pc_w + inst_w;
    endfunction

    function automatic int off_pc(input int inst_w);
        return inst_w;
    endfunction

    function automatic int off_wdata(input int inst_w, input int pc_w);
        return inst_w + pc_w;
    endfunction

    function automatic int off_waddr(input int inst_w, input int pc_w, input int xlen);
        return inst_w + pc_w + xlen;
    endfunction

    function automatic int off_we(input int inst_w, input int pc_w, input int xlen);
        return inst_w + pc_w + xlen + RF_ADDR_W;
    endfunction

    function automatic int off_valid(input int inst_w, input int pc_w, input int xlen);
        return inst_w + pc_w + xlen + RF_ADDR_W + 1;
    endfunction

    // Register-file / forwarding lane is {we, waddr, wdata}.
    function automatic int wb2rf_lane_w(input int xlen);
        return 1 + RF_ADDR_W + xlen;
    endfunction

    function automatic int trace_entry_w(input int lanes, input int pc_w, input int inst_w);
        return lanes * (1 + pc_w + inst_w);
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous FIFO with a show-ahead head register; rdata reads 0 while empty.
// Pushes while full and pops while empty are ignored.
module wb_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             push_acc;
    logic             pop_acc;

    assign full        = (count_reg == (AW+1)'(DEPTH));
    assign empty       = (count_reg == '0);
    assign count       = count_reg;
    assign push_acc    = push & ~full;
    assign pop_acc     = pop & ~empty;
    assign rd_ptr_next = pop_acc ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    assign rdata       = empty ? '0 : head_reg;

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Head is prefetched one edge ahead; bypass covers a write into the slot about to become head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
        end else if (push_acc && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wdata;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push_acc, pop_acc})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage_multi.sv
// LANES-wide writeback stage: bundle register, x0/same-rd write masking, retire counter, debug fan-out.
// Optional trace FIFO of retired bundles is built when WB_TRACE_FIFO_EN is defined.
module wb_stage_multi
    import wb_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int XLEN        = 64,
    parameter int PC_W        = 64,
    parameter int INST_W      = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [5:0]                             stall,
    input  logic [LANES*(2+RF_ADDR_W+XLEN+PC_W+INST_W)-1:0] mem2wb_bus,
    output logic [LANES*(1+RF_ADDR_W+XLEN)-1:0]    wb2rf_bus,
    output logic [LANES*(1+RF_ADDR_W+XLEN)-1:0]    wb2ex_fwd,
    output logic [63:0]                            retire_cnt,
    output logic                                   stall_req,
    output logic                                   trace_valid,
    input  logic                                   trace_ready,
    output logic [LANES*(1+PC_W+INST_W)-1:0]       trace_data,
    output logic                                   trace_ovf,
    output logic [LANES*PC_W-1:0]                  debug_wb_pc,
    output logic [LANES*8-1:0]                     debug_wb_rf_we,
    output logic [LANES*RF_ADDR_W-1:0]             debug_wb_rf_wnum,
    output logic [LANES*XLEN-1:0]                  debug_wb_rf_wdata
);

    localparam int LB        = lane_bits(XLEN, PC_W, INST_W);
    localparam int RFW       = wb2rf_lane_w(XLEN);
    localparam int OFF_PC    = off_pc(INST_W);
    localparam int OFF_WDATA = off_wdata(INST_W, PC_W);
    localparam int OFF_WADDR = off_waddr(INST_W, PC_W, XLEN);
    localparam int OFF_WE    = off_we(INST_W, PC_W, XLEN);
    localparam int OFF_VALID = off_valid(INST_W, PC_W, XLEN);

    logic [LANES*LB-1:0]              bundle_reg;
    logic [63:0]                      retire_cnt_reg;
    logic                             load_en;
    logic                             bubble_en;
    logic [LANES-1:0]                 in_valid;
    logic [2:0]                       in_valid_cnt;
    logic [LANES-1:0]                 lane_valid;
    logic [LANES-1:0]                 cand_we;
    logic [LANES-1:0]                 eff_we;
    logic [LANES-1:0][RF_ADDR_W-1:0]  lane_waddr;
    logic [LANES-1:0][XLEN-1:0]       lane_wdata;
    logic [LANES-1:0][PC_W-1:0]       lane_pc;
    logic [LANES*INST_W-1:0]          unused_inst;
    logic                             unused_stall;

    assign load_en      = ~stall[4];
    assign bubble_en    = stall[4] & ~stall[5];
    assign unused_stall = ^stall[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_reg <= '0;
        end else if (bubble_en) begin
            bundle_reg <= '0;
        end else if (load_en) begin
            bundle_reg <= mem2wb_bus;
        end
    end

    always_comb begin
        in_valid_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            in_valid_cnt = in_valid_cnt + {2'b00, in_valid[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_reg <= '0;
        end else if (load_en) begin
            retire_cnt_reg <= retire_cnt_reg + {61'd0, in_valid_cnt};
        end
    end

    assign retire_cnt = retire_cnt_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign in_valid[gi]   = mem2wb_bus[gi*LB + OFF_VALID];
        assign lane_valid[gi] = bundle_reg[gi*LB + OFF_VALID];
        assign lane_waddr[gi] = bundle_reg[gi*LB + OFF_WADDR +: RF_ADDR_W];
        assign lane_wdata[gi] = bundle_reg[gi*LB + OFF_WDATA +: XLEN];
        assign lane_pc[gi]    = bundle_reg[gi*LB + OFF_PC +: PC_W];
        assign unused_inst[gi*INST_W +: INST_W] = bundle_reg[gi*LB +: INST_W];
        assign cand_we[gi]    = lane_valid[gi] & bundle_reg[gi*LB + OFF_WE] & (lane_waddr[gi] != '0);

        assign wb2rf_bus[gi*RFW +: RFW] = eff_we[gi] ? {1'b1, lane_waddr[gi], lane_wdata[gi]} : '0;
        assign debug_wb_pc[gi*PC_W +: PC_W]                = lane_valid[gi] ? lane_pc[gi] : '0;
        assign debug_wb_rf_we[gi*8 +: 8]                   = {8{eff_we[gi]}};
        assign debug_wb_rf_wnum[gi*RF_ADDR_W +: RF_ADDR_W] = eff_we[gi] ? lane_waddr[gi] : '0;
        assign debug_wb_rf_wdata[gi*XLEN +: XLEN]          = eff_we[gi] ? lane_wdata[gi] : '0;
    end

    // Younger (higher) lane wins when two lanes target the same register.
    always_comb begin
        eff_we = '0;
        for (int i = 0; i < LANES; i++) begin
            eff_we[i] = cand_we[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (cand_we[j] && (lane_waddr[j] == lane_waddr[i])) begin
                    eff_we[i] = 1'b0;
                end
            end
        end
    end

    assign wb2ex_fwd = wb2rf_bus;

`ifdef WB_TRACE_FIFO_EN
    localparam int TLW = 1 + PC_W + INST_W;
    localparam int TW  = trace_entry_w(LANES, PC_W, INST_W);
    localparam int CW  = $clog2(TRACE_DEPTH) + 1;

    logic [TW-1:0] trace_entry;
    logic          trace_push;
    logic          trace_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] unused_fifo_count;
    logic          trace_ovf_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_trace_lane
        assign trace_entry[gi*TLW +: TLW] = in_valid[gi]
            ? {1'b1, mem2wb_bus[gi*LB + OFF_PC +: PC_W], mem2wb_bus[gi*LB +: INST_W]}
            : '0;
    end

    assign trace_push  = load_en & (|in_valid);
    assign trace_valid = ~fifo_empty;
    assign trace_pop   = trace_valid & trace_ready;

    wb_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TW)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (trace_push),
        .pop   (trace_pop),
        .wdata (trace_entry),
        .rdata (trace_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_ovf_reg <= 1'b0;
        end else if (trace_push && fifo_full) begin
            trace_ovf_reg <= 1'b1;
        end
    end

    assign trace_ovf = trace_ovf_reg;
    assign stall_req = fifo_full;
`else
    logic unused_trace_ready;

    assign unused_trace_ready = trace_ready;
    assign trace_valid        = 1'b0;
    assign trace_data         = '0;
    assign trace_ovf          = 1'b0;
    assign stall_req          = 1'b0;
`endif

endmodule
